// File: rtl/fpu_issue_sched_pkg.sv
// Shared definitions for the FPU issue scheduler: op select codes, per-op
// write-back latencies, the write-back tag record and a latency lookup.
package fpu_issue_sched_pkg;

   // Op select codes driven on issue_sel / wb_sel (result mux select)
   typedef enum logic [1:0] {
      FPU_ADD  = 2'd0,
      FPU_MADD = 2'd1,
      FPU_CVT  = 2'd2,
      FPU_SGNJ = 2'd3
   } fpu_sel_e;

   // Issue-to-write-back latencies, all within 1..8
   localparam int FPU_LAT_ADD  = 2;
   localparam int FPU_LAT_MADD = 4;
   localparam int FPU_LAT_CVT  = 1;
   localparam int FPU_LAT_SGNJ = 1;

   // MADD is the deepest pipe, so it sizes the reservation window
   localparam int FPU_MAXLAT = FPU_LAT_MADD;

   // Tag carried alongside each write-back reservation
   typedef struct packed {
      logic [4:0] rd;
      logic [1:0] sel;
   } wb_tag_t;

   // Write-back latency of an op select code
   function automatic logic [3:0] lat_of(input logic [1:0] sel);
      case (sel)
         FPU_ADD:  lat_of = 4'(FPU_LAT_ADD);
         FPU_MADD: lat_of = 4'(FPU_LAT_MADD);
         FPU_CVT:  lat_of = 4'(FPU_LAT_CVT);
         default:  lat_of = 4'(FPU_LAT_SGNJ);
      endcase
   endfunction

endpackage

// File: rtl/fpu_wb_resv.sv
// Write-back reservation shift register. Slot k set means a result lands on
// the write-back port k cycles from now; each slot carries the {rd,sel} tag
// of that result. Inserting an op of latency L fills slot L-1 so that it
// reaches slot 0 exactly L cycles after issue.
module fpu_wb_resv
   import fpu_issue_sched_pkg::*;
#(
   parameter int MAXLAT = FPU_MAXLAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_insert,
   input  logic [3:0]        i_lat,
   input  wb_tag_t           i_tag,
   output logic [MAXLAT-1:0] o_resv,
   output wb_tag_t           o_tag0
);

   logic [MAXLAT-1:0] r_resv;
   wb_tag_t           r_tag [MAXLAT];

   logic [MAXLAT-1:0] w_resv_up;
   wb_tag_t           w_tag_up [MAXLAT];
   logic [MAXLAT-1:0] w_hit;
   logic [MAXLAT-1:0] w_resv_next;
   wb_tag_t           w_tag_next [MAXLAT];

   // Per slot: what shifts in from above, and whether the new op lands here
   for (genvar gi = 0; gi < MAXLAT; gi++) begin : g_slot
      if (gi == MAXLAT - 1) begin : g_top
         assign w_resv_up[gi] = 1'b0;
         assign w_tag_up[gi]  = '0;
      end else begin : g_mid
         assign w_resv_up[gi] = r_resv[gi+1];
         assign w_tag_up[gi]  = r_tag[gi+1];
      end
      assign w_hit[gi]       = i_insert && (i_lat == 4'(gi + 1));
      assign w_resv_next[gi] = w_resv_up[gi] | w_hit[gi];
      // Hazard logic guarantees a shifted entry and an insert never share a slot
      assign w_tag_next[gi]  = w_hit[gi]     ? i_tag :
                               w_resv_up[gi] ? w_tag_up[gi] : '0;
   end

   // Shift the window down one slot per cycle; reset or flush empties it
   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_resv <= '0;
         for (int k = 0; k < MAXLAT; k++) r_tag[k] <= '0;
      end else begin
         r_resv <= w_resv_next;
         for (int k = 0; k < MAXLAT; k++) r_tag[k] <= w_tag_next[k];
      end
   end

   assign o_resv = r_resv;
   assign o_tag0 = r_tag[0];

endmodule

// File: rtl/fpu_issue_sched.sv
// Issue scheduler for the multi-cycle FPU datapath. Holds the f-register
// pending-write scoreboard, the RAW/WAW/write-back-port hazard checks and the
// in-flight count; the reservation window lives in fpu_wb_resv.
// Build option: define FPU_SCHED_FWD_EN when the datapath bypasses the
// write-back result, letting a dependent op issue in the write-back cycle.
module fpu_issue_sched
   import fpu_issue_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [1:0]  issue_sel,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  issue_fs1,
   input  logic [4:0]  issue_fs2,
   input  logic [4:0]  issue_fs3,
   input  logic [2:0]  issue_src_mask,
   input  logic        flush,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [1:0]  wb_sel,
   output logic [31:0] busy_vec,
   output logic [3:0]  outstanding
);

   logic [31:0]           r_busy;
   logic [3:0]            w_lat;
   logic                  w_fire;
   logic [FPU_MAXLAT-1:0] w_resv;
   wb_tag_t               w_tag0;
   wb_tag_t               w_new_tag;
   logic                  w_wb_conflict;
   logic [4:0]            w_fs [3];
   logic [2:0]            w_src_hit;
   logic                  w_raw;
   logic                  w_waw;
   logic [31:0]           w_set;
   logic [31:0]           w_clr;

   assign w_lat     = lat_of(issue_sel);
   assign w_fire    = issue_valid & issue_ready;
   assign w_new_tag = '{rd: issue_rd, sel: issue_sel};

   fpu_wb_resv #(
      .MAXLAT (FPU_MAXLAT)
   ) u_resv (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_flush  (flush),
      .i_insert (w_fire),
      .i_lat    (w_lat),
      .i_tag    (w_new_tag),
      .o_resv   (w_resv),
      .o_tag0   (w_tag0)
   );

   // Write-back port: a due result is dropped in a flush cycle or under reset
   assign wb_valid = w_resv[0] & ~flush & rst_n;
   assign wb_rd    = wb_valid ? w_tag0.rd  : 5'd0;
   assign wb_sel   = wb_valid ? w_tag0.sel : 2'd0;

   // Port collision: the new op would land in the slot an older op will shift into
   always_comb begin
      w_wb_conflict = 1'b0;
      for (int k = 1; k < FPU_MAXLAT; k++) begin
         if (w_lat == 4'(k)) w_wb_conflict = w_resv[k];
      end
   end

   assign w_fs[0] = issue_fs1;
   assign w_fs[1] = issue_fs2;
   assign w_fs[2] = issue_fs3;

   // RAW per source: only sources the op actually reads can stall it
   for (genvar gi = 0; gi < 3; gi++) begin : g_src
`ifdef FPU_SCHED_FWD_EN
      assign w_src_hit[gi] = issue_src_mask[gi] & r_busy[w_fs[gi]] &
                             ~(wb_valid && (wb_rd == w_fs[gi]));
`else
      assign w_src_hit[gi] = issue_src_mask[gi] & r_busy[w_fs[gi]];
`endif
   end

   assign w_raw = |w_src_hit;
   assign w_waw = r_busy[issue_rd];

   assign issue_ready = rst_n & ~flush & ~w_wb_conflict & ~w_raw & ~w_waw;

   assign w_set = w_fire   ? (32'd1 << issue_rd) : 32'd0;
   assign w_clr = wb_valid ? (32'd1 << wb_rd)    : 32'd0;

   // Scoreboard: mark destination pending on issue, release it on write-back
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign busy_vec = r_busy;

   // In-flight count is the number of occupied reservation slots
   always_comb begin
      outstanding = 4'd0;
      for (int k = 0; k < FPU_MAXLAT; k++) begin
         outstanding = outstanding + 4'(w_resv[k]);
      end
   end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: a write-back scoreboard monitor,
// a table of two-op hazard vectors and directed multi-cycle sequences.
module tb_fpu_issue_sched;
   import fpu_issue_sched_pkg::*;

`ifdef FPU_SCHED_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [1:0]  issue_sel;
   logic [4:0]  issue_rd;
   logic [4:0]  issue_fs1;
   logic [4:0]  issue_fs2;
   logic [4:0]  issue_fs3;
   logic [2:0]  issue_src_mask;
   logic        flush;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_sel;
   logic [31:0] busy_vec;
   logic [3:0]  outstanding;

   fpu_issue_sched dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_sel      (issue_sel),
      .issue_rd       (issue_rd),
      .issue_fs1      (issue_fs1),
      .issue_fs2      (issue_fs2),
      .issue_fs3      (issue_fs3),
      .issue_src_mask (issue_src_mask),
      .flush          (flush),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_sel         (wb_sel),
      .busy_vec       (busy_vec),
      .outstanding    (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Bench-side latency table
   function automatic int lat_tb(input logic [1:0] sel);
      case (sel)
         FPU_ADD:  return 2;
         FPU_MADD: return 4;
         FPU_CVT:  return 1;
         default:  return 1;
      endcase
   endfunction

   // Scoreboard of expected write-backs, pushed when an op fires
   typedef struct {
      int         due;
      logic [4:0] rd;
      logic [1:0] sel;
   } exp_t;
   exp_t sb[$];

   int          m_n;
   int          m_hit;
   logic [31:0] m_eb;

   always @(negedge clk) begin
      if (!rst_n || flush) begin
         chk("wb_valid_blocked", int'(wb_valid), 0);
         chk("ready_blocked", int'(issue_ready), 0);
         sb.delete();
      end else begin
         m_n = 0; m_eb = '0; m_hit = -1;
         foreach (sb[i]) begin
            if (sb[i].due >= cyc) begin
               m_n++;
               m_eb[sb[i].rd] = 1'b1;
               if (sb[i].due == cyc) m_hit = i;
            end
         end
         chk("outstanding", int'(outstanding), m_n);
         chk("busy_vec", int'(busy_vec), int'(m_eb));
         if (m_hit >= 0) begin
            chk("wb_valid", int'(wb_valid), 1);
            chk("wb_rd", int'(wb_rd), int'(sb[m_hit].rd));
            chk("wb_sel", int'(wb_sel), int'(sb[m_hit].sel));
            sb.delete(m_hit);
         end else begin
            chk("wb_valid_quiet", int'(wb_valid), 0);
            chk("wb_rd_quiet", int'(wb_rd), 0);
         end
         if (issue_valid && issue_ready)
            sb.push_back('{due: cyc + lat_tb(issue_sel), rd: issue_rd, sel: issue_sel});
      end
   end

   task automatic idle();
      issue_valid = 1'b0; issue_sel = 2'd0; issue_rd = 5'd0;
      issue_fs1 = 5'd0; issue_fs2 = 5'd0; issue_fs3 = 5'd0;
      issue_src_mask = 3'b000; flush = 1'b0;
   endtask

   task automatic present(input logic [1:0] sel, input logic [4:0] rd,
                          input logic [4:0] f1, input logic [4:0] f2,
                          input logic [4:0] f3, input logic [2:0] mask);
      issue_valid = 1'b1; issue_sel = sel; issue_rd = rd;
      issue_fs1 = f1; issue_fs2 = f2; issue_fs3 = f3; issue_src_mask = mask;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      idle();
      repeat (n) next();
   endtask

   // Hold the presented op until it fires; returns cycles since c0 (-1 on timeout)
   task automatic wait_fire(input int start, output int fired);
      fired = -1;
      for (int k = start; k <= start + 10 && fired < 0; k++) begin
         @(negedge clk);
         if (issue_ready) fired = k;
         next();
      end
      idle();
   endtask

   typedef struct {
      logic [1:0] a_sel;
      logic [4:0] a_rd;
      int         gap;
      logic [1:0] b_sel;
      logic [4:0] b_rd;
      logic [4:0] b_fs1;
      logic [4:0] b_fs2;
      logic [4:0] b_fs3;
      logic [2:0] b_mask;
      logic       exp_ready;
   } vec_t;
   vec_t vt [14];

   int fired;

   initial begin
      // op A issued at c0, op B presented at c(gap), expected issue_ready for B
      vt[0]  = '{FPU_ADD,  5'd3,  1, FPU_ADD,  5'd4,  5'd3,  5'd1,  5'd0,  3'b011, 1'b0};
      vt[1]  = '{FPU_ADD,  5'd3,  1, FPU_ADD,  5'd4,  5'd1,  5'd2,  5'd0,  3'b011, 1'b1};
      vt[2]  = '{FPU_ADD,  5'd3,  1, FPU_CVT,  5'd3,  5'd0,  5'd0,  5'd0,  3'b000, 1'b0};
      vt[3]  = '{FPU_MADD, 5'd1,  2, FPU_ADD,  5'd2,  5'd5,  5'd6,  5'd0,  3'b011, 1'b0};
      vt[4]  = '{FPU_MADD, 5'd1,  1, FPU_ADD,  5'd2,  5'd5,  5'd6,  5'd0,  3'b011, 1'b1};
      vt[5]  = '{FPU_MADD, 5'd1,  3, FPU_CVT,  5'd2,  5'd0,  5'd0,  5'd0,  3'b000, 1'b0};
      vt[6]  = '{FPU_MADD, 5'd1,  1, FPU_MADD, 5'd2,  5'd7,  5'd8,  5'd9,  3'b111, 1'b1};
      vt[7]  = '{FPU_ADD,  5'd10, 1, FPU_MADD, 5'd11, 5'd1,  5'd2,  5'd10, 3'b111, 1'b0};
      vt[8]  = '{FPU_ADD,  5'd10, 1, FPU_MADD, 5'd11, 5'd1,  5'd2,  5'd10, 3'b011, 1'b1};
      vt[9]  = '{FPU_ADD,  5'd0,  1, FPU_ADD,  5'd1,  5'd0,  5'd2,  5'd0,  3'b011, 1'b0};
      vt[10] = '{FPU_SGNJ, 5'd12, 1, FPU_ADD,  5'd14, 5'd12, 5'd13, 5'd0,  3'b011, FWD};
      vt[11] = '{FPU_ADD,  5'd5,  2, FPU_SGNJ, 5'd6,  5'd5,  5'd7,  5'd0,  3'b011, FWD};
      vt[12] = '{FPU_CVT,  5'd6,  1, FPU_CVT,  5'd6,  5'd0,  5'd0,  5'd0,  3'b000, 1'b0};
      vt[13] = '{FPU_ADD,  5'd9,  2, FPU_CVT,  5'd13, 5'd0,  5'd0,  5'd0,  3'b000, 1'b1};

      // Reset held 3 cycles with an op presented
      rst_n = 1'b0;
      idle();
      present(FPU_ADD, 5'd3, 5'd0, 5'd0, 5'd0, 3'b011);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ready", int'(issue_ready), 0);
         chk("rst_wb_valid", int'(wb_valid), 0);
         if (i > 0) chk("rst_busy", int'(busy_vec), 0);
         next();
      end
      rst_n = 1'b1;
      idle();
      @(negedge clk);
      chk("post_rst_ready", int'(issue_ready), 1);
      chk("post_rst_outstanding", int'(outstanding), 0);
      next();

      // ADD f3: busy in c1,c2; write-back only in c2; released in c3
      present(FPU_ADD, 5'd3, 5'd1, 5'd2, 5'd0, 3'b011);
      @(negedge clk); chk("add_ready", int'(issue_ready), 1);
      next(); idle();
      @(negedge clk); chk("add_busy_c1", int'(busy_vec[3]), 1); chk("add_wb_c1", int'(wb_valid), 0);
      next();
      @(negedge clk); chk("add_busy_c2", int'(busy_vec[3]), 1); chk("add_wb_c2", int'(wb_valid), 1);
      chk("add_wb_rd_c2", int'(wb_rd), 3); chk("add_wb_sel_c2", int'(wb_sel), int'(FPU_ADD));
      next();
      @(negedge clk); chk("add_busy_c3", int'(busy_vec[3]), 0); chk("add_wb_c3", int'(wb_valid), 0);
      drain(4);

      // MADD f1 at c0 vs ADD f2 at c2: port collision delays ADD one cycle
      present(FPU_MADD, 5'd1, 5'd10, 5'd11, 5'd12, 3'b111);
      @(negedge clk); chk("madd_ready", int'(issue_ready), 1);
      next(); idle(); next();
      present(FPU_ADD, 5'd2, 5'd13, 5'd14, 5'd0, 3'b011);
      @(negedge clk); chk("coll_ready_c2", int'(issue_ready), 0);
      next();
      @(negedge clk); chk("coll_ready_c3", int'(issue_ready), 1);
      next(); idle();
      @(negedge clk); chk("coll_wb_c4", int'(wb_valid), 1); chk("coll_wb_rd_c4", int'(wb_rd), 1);
      next();
      @(negedge clk); chk("coll_wb_c5", int'(wb_valid), 1); chk("coll_wb_rd_c5", int'(wb_rd), 2);
      drain(4);

      // RAW on ADD result: issue cycle depends on forwarding
      present(FPU_ADD, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000);
      next();
      present(FPU_SGNJ, 5'd6, 5'd5, 5'd7, 5'd0, 3'b011);
      wait_fire(1, fired);
      chk("raw_fire_cycle", fired, FWD ? 2 : 3);
      drain(4);

      // Flush kills an in-flight MADD
      present(FPU_MADD, 5'd4, 5'd1, 5'd2, 5'd3, 3'b111);
      next(); idle(); flush = 1'b1;
      @(negedge clk); chk("flush_wb", int'(wb_valid), 0);
      next(); flush = 1'b0;
      @(negedge clk); chk("flush_busy", int'(busy_vec), 0); chk("flush_outstanding", int'(outstanding), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("flush_no_wb", int'(wb_valid), 0);
         next();
      end

      // CVT with busy destination waits until the cycle after write-back
      present(FPU_MADD, 5'd7, 5'd20, 5'd21, 5'd22, 3'b111);
      next();
      present(FPU_CVT, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000);
      wait_fire(1, fired);
      chk("waw_fire_cycle", fired, 5);
      drain(5);
      present(FPU_MADD, 5'd7, 5'd20, 5'd21, 5'd22, 3'b111);
      next();
      present(FPU_CVT, 5'd8, 5'd0, 5'd0, 5'd0, 3'b000);
      @(negedge clk); chk("cvt_free_ready", int'(issue_ready), 1);
      drain(6);

      // Table of two-op hazard vectors
      for (int i = 0; i < 14; i++) begin
         present(vt[i].a_sel, vt[i].a_rd, 5'd0, 5'd0, 5'd0, 3'b000);
         @(negedge clk); chk($sformatf("vec%0d_a_ready", i), int'(issue_ready), 1);
         next(); idle();
         repeat (vt[i].gap - 1) next();
         present(vt[i].b_sel, vt[i].b_rd, vt[i].b_fs1, vt[i].b_fs2, vt[i].b_fs3, vt[i].b_mask);
         @(negedge clk); chk($sformatf("vec%0d_b_ready", i), int'(issue_ready), int'(vt[i].exp_ready));
         next();
         drain(6);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle=%0d", cyc);
      $fatal(1);
   end

endmodule
